// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: turns a load/store held in EXE/MEM into a
// request/acknowledge transaction with data memory, stalling the pipeline and
// bubbling MEM/WB until the access completes or times out.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        MemRead_IN,
  input  logic        MemWrite_IN,
  input  logic [31:0] ALUResult_IN,
  input  logic [31:0] MemWriteData_IN,
  input  logic [5:0]  MemControl_IN,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_RDATA,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  output logic [5:0]  MEM_CTRL,
  output logic        STALL_PIPE,
  output logic        FLUSH_MEMWB,
  output logic [31:0] ReadData_OUT,
  output logic        TIMEOUT_ERR
);

  // Counter only has to reach TIMEOUT_CYCLES-1; keep at least one bit.
  localparam int unsigned CNT_W =
    (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           nextState;
  logic [CNT_W-1:0] cycleCount;
  logic             memOp;
  logic             timeoutHit;

  assign memOp      = MemRead_IN | MemWrite_IN;
  assign timeoutHit = (cycleCount == CNT_LIMIT);

  // State register; reset abandons any access in flight.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic; ACK takes priority over timeout.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (memOp) begin
          nextState = BUSY;
        end
      end
      BUSY: begin
        if (MEM_ACK || timeoutHit) begin
          nextState = DONE;
        end
      end
      DONE: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Pipeline control: stall from detection through BUSY, release in DONE.
  always_comb begin
    STALL_PIPE  = 1'b0;
    FLUSH_MEMWB = 1'b0;
    case (state)
      IDLE: begin
        STALL_PIPE  = memOp;
        FLUSH_MEMWB = memOp;
      end
      BUSY: begin
        STALL_PIPE  = 1'b1;
        FLUSH_MEMWB = 1'b1;
      end
      default: begin
        STALL_PIPE  = 1'b0;
        FLUSH_MEMWB = 1'b0;
      end
    endcase
  end

  // Request fields, cycle counter, captured load data and sticky timeout flag.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      MEM_REQ      <= 1'b0;
      MEM_WE       <= 1'b0;
      MEM_ADDR     <= 32'h0;
      MEM_WDATA    <= 32'h0;
      MEM_CTRL     <= 6'h0;
      ReadData_OUT <= 32'h0;
      TIMEOUT_ERR  <= 1'b0;
      cycleCount   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (memOp) begin
            MEM_REQ    <= 1'b1;
            MEM_WE     <= MemWrite_IN;
            MEM_ADDR   <= ALUResult_IN;
            MEM_WDATA  <= MemWriteData_IN;
            MEM_CTRL   <= MemControl_IN;
            cycleCount <= '0;
          end
        end
        BUSY: begin
          if (cycleCount != CNT_MAX) begin
            cycleCount <= cycleCount + CNT_W'(1);
          end
          if (MEM_ACK) begin
            MEM_REQ <= 1'b0;
            if (!MEM_WE) begin
              ReadData_OUT <= MEM_RDATA;
            end
          end else if (timeoutHit) begin
            MEM_REQ      <= 1'b0;
            ReadData_OUT <= 32'h0;
            TIMEOUT_ERR  <= 1'b1;
          end
        end
        default: begin
          MEM_REQ <= MEM_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a short timeout (4 BUSY cycles).
module tb_mem_access_ctrl;

  logic        CLOCK;
  logic        RESET;
  logic        MemRead_IN;
  logic        MemWrite_IN;
  logic [31:0] ALUResult_IN;
  logic [31:0] MemWriteData_IN;
  logic [5:0]  MemControl_IN;
  logic        MEM_ACK;
  logic [31:0] MEM_RDATA;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic [5:0]  MEM_CTRL;
  logic        STALL_PIPE;
  logic        FLUSH_MEMWB;
  logic [31:0] ReadData_OUT;
  logic        TIMEOUT_ERR;

  int total = 0;
  int bad   = 0;

  mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .CLOCK           (CLOCK),
    .RESET           (RESET),
    .MemRead_IN      (MemRead_IN),
    .MemWrite_IN     (MemWrite_IN),
    .ALUResult_IN    (ALUResult_IN),
    .MemWriteData_IN (MemWriteData_IN),
    .MemControl_IN   (MemControl_IN),
    .MEM_ACK         (MEM_ACK),
    .MEM_RDATA       (MEM_RDATA),
    .MEM_REQ         (MEM_REQ),
    .MEM_WE          (MEM_WE),
    .MEM_ADDR        (MEM_ADDR),
    .MEM_WDATA       (MEM_WDATA),
    .MEM_CTRL        (MEM_CTRL),
    .STALL_PIPE      (STALL_PIPE),
    .FLUSH_MEMWB     (FLUSH_MEMWB),
    .ReadData_OUT    (ReadData_OUT),
    .TIMEOUT_ERR     (TIMEOUT_ERR)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic clear_inputs();
    MemRead_IN      = 1'b0;
    MemWrite_IN     = 1'b0;
    ALUResult_IN    = 32'h0;
    MemWriteData_IN = 32'h0;
    MemControl_IN   = 6'h0;
    MEM_ACK         = 1'b0;
    MEM_RDATA       = 32'h0;
  endtask

  task automatic test_reset();
    clear_inputs();
    RESET = 1'b0;
    #3;
    total++; if (MEM_REQ !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", MEM_REQ); end
    total++; if (MEM_ADDR !== 32'h0 || MEM_WDATA !== 32'h0 || MEM_CTRL !== 6'h0 || MEM_WE !== 1'b0) begin bad++; $display("FAIL reset_fields got=%h/%h/%h/%b want=0", MEM_ADDR, MEM_WDATA, MEM_CTRL, MEM_WE); end
    total++; if (ReadData_OUT !== 32'h0 || TIMEOUT_ERR !== 1'b0) begin bad++; $display("FAIL reset_rd_err got=%h/%b want=0/0", ReadData_OUT, TIMEOUT_ERR); end
    total++; if (STALL_PIPE !== 1'b0 || FLUSH_MEMWB !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b/%b want=0/0", STALL_PIPE, FLUSH_MEMWB); end
    tick();
    RESET = 1'b1;
    tick();
    // Stray ACK while idle must be ignored.
    MEM_ACK = 1'b1; MEM_RDATA = 32'hA5A5A5A5;
    tick();
    MEM_ACK = 1'b0; MEM_RDATA = 32'h0;
    total++; if (ReadData_OUT !== 32'h0 || MEM_REQ !== 1'b0) begin bad++; $display("FAIL idle_ack got=%h/%b want=0/0", ReadData_OUT, MEM_REQ); end
  endtask

  task automatic test_load();
    MemRead_IN = 1'b1; ALUResult_IN = 32'h100; MemControl_IN = 6'h05;
    #1;
    total++; if (STALL_PIPE !== 1'b1 || FLUSH_MEMWB !== 1'b1) begin bad++; $display("FAIL load_detect got=%b/%b want=1/1", STALL_PIPE, FLUSH_MEMWB); end
    total++; if (MEM_REQ !== 1'b0) begin bad++; $display("FAIL load_req_early got=%b want=0", MEM_REQ); end
    tick();
    total++; if (MEM_REQ !== 1'b1 || MEM_WE !== 1'b0 || MEM_ADDR !== 32'h100 || MEM_CTRL !== 6'h05) begin bad++; $display("FAIL load_req got=%b/%b/%h/%h want=1/0/100/05", MEM_REQ, MEM_WE, MEM_ADDR, MEM_CTRL); end
    total++; if (STALL_PIPE !== 1'b1) begin bad++; $display("FAIL load_busy1_stall got=%b want=1", STALL_PIPE); end
    tick();
    total++; if (STALL_PIPE !== 1'b1 || MEM_REQ !== 1'b1) begin bad++; $display("FAIL load_busy2 got=%b/%b want=1/1", STALL_PIPE, MEM_REQ); end
    MEM_ACK = 1'b1; MEM_RDATA = 32'hDEADBEEF;
    tick();
    MEM_ACK = 1'b0; MEM_RDATA = 32'h0;
    #1;
    total++; if (ReadData_OUT !== 32'hDEADBEEF) begin bad++; $display("FAIL load_data got=%h want=deadbeef", ReadData_OUT); end
    total++; if (STALL_PIPE !== 1'b0 || FLUSH_MEMWB !== 1'b0 || MEM_REQ !== 1'b0) begin bad++; $display("FAIL load_done got=%b/%b/%b want=0/0/0", STALL_PIPE, FLUSH_MEMWB, MEM_REQ); end
    clear_inputs();
    tick();
    total++; if (STALL_PIPE !== 1'b0 || MEM_REQ !== 1'b0) begin bad++; $display("FAIL load_idle got=%b/%b want=0/0", STALL_PIPE, MEM_REQ); end
  endtask

  task automatic test_store();
    MemWrite_IN = 1'b1; ALUResult_IN = 32'h200; MemWriteData_IN = 32'h12345678; MemControl_IN = 6'h03;
    tick();
    total++; if (MEM_REQ !== 1'b1 || MEM_WE !== 1'b1 || MEM_WDATA !== 32'h12345678 || MEM_ADDR !== 32'h200) begin bad++; $display("FAIL store_req got=%b/%b/%h/%h want=1/1/12345678/200", MEM_REQ, MEM_WE, MEM_WDATA, MEM_ADDR); end
    // Disturb inputs: request fields must not follow them while busy.
    MemWriteData_IN = 32'hFFFF0000; ALUResult_IN = 32'h999;
    MEM_ACK = 1'b1; MEM_RDATA = 32'hBAD0BAD0;
    #1;
    total++; if (MEM_WDATA !== 32'h12345678 || MEM_ADDR !== 32'h200) begin bad++; $display("FAIL store_hold got=%h/%h want=12345678/200", MEM_WDATA, MEM_ADDR); end
    tick();
    MEM_ACK = 1'b0; MEM_RDATA = 32'h0;
    total++; if (ReadData_OUT !== 32'hDEADBEEF || MEM_REQ !== 1'b0 || STALL_PIPE !== 1'b0) begin bad++; $display("FAIL store_done got=%h/%b/%b want=deadbeef/0/0", ReadData_OUT, MEM_REQ, STALL_PIPE); end
    clear_inputs();
    tick();
  endtask

  task automatic test_read_write_conflict();
    MemRead_IN = 1'b1; MemWrite_IN = 1'b1; ALUResult_IN = 32'h240; MemWriteData_IN = 32'h0BADF00D;
    tick();
    total++; if (MEM_WE !== 1'b1 || MEM_REQ !== 1'b1) begin bad++; $display("FAIL rw_is_write got=%b/%b want=1/1", MEM_WE, MEM_REQ); end
    MEM_ACK = 1'b1; MEM_RDATA = 32'h77777777;
    tick();
    MEM_ACK = 1'b0;
    total++; if (ReadData_OUT !== 32'hDEADBEEF) begin bad++; $display("FAIL rw_no_capture got=%h want=deadbeef", ReadData_OUT); end
    clear_inputs();
    tick();
  endtask

  task automatic test_ack_at_limit();
    MemRead_IN = 1'b1; ALUResult_IN = 32'h300;
    tick();
    tick();
    tick();
    tick();
    total++; if (MEM_REQ !== 1'b1 || STALL_PIPE !== 1'b1) begin bad++; $display("FAIL limit_busy4 got=%b/%b want=1/1", MEM_REQ, STALL_PIPE); end
    MEM_ACK = 1'b1; MEM_RDATA = 32'hCAFEF00D;
    tick();
    MEM_ACK = 1'b0; MEM_RDATA = 32'h0;
    total++; if (ReadData_OUT !== 32'hCAFEF00D || TIMEOUT_ERR !== 1'b0) begin bad++; $display("FAIL limit_ack_wins got=%h/%b want=cafef00d/0", ReadData_OUT, TIMEOUT_ERR); end
    total++; if (STALL_PIPE !== 1'b0 || MEM_REQ !== 1'b0) begin bad++; $display("FAIL limit_done got=%b/%b want=0/0", STALL_PIPE, MEM_REQ); end
    clear_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    MemRead_IN = 1'b1; ALUResult_IN = 32'h400;
    tick();
    MEM_ACK = 1'b1; MEM_RDATA = 32'h11111111;
    tick();
    MEM_ACK = 1'b0; MEM_RDATA = 32'h0;
    // DONE: pipeline advances, the next load appears in EXE/MEM.
    ALUResult_IN = 32'h404;
    #1;
    total++; if (ReadData_OUT !== 32'h11111111 || STALL_PIPE !== 1'b0) begin bad++; $display("FAIL b2b_first got=%h/%b want=11111111/0", ReadData_OUT, STALL_PIPE); end
    tick();
    total++; if (STALL_PIPE !== 1'b1 || MEM_REQ !== 1'b0) begin bad++; $display("FAIL b2b_redetect got=%b/%b want=1/0", STALL_PIPE, MEM_REQ); end
    tick();
    total++; if (MEM_REQ !== 1'b1 || MEM_ADDR !== 32'h404) begin bad++; $display("FAIL b2b_second_req got=%b/%h want=1/404", MEM_REQ, MEM_ADDR); end
    MEM_ACK = 1'b1; MEM_RDATA = 32'h22222222;
    tick();
    MEM_ACK = 1'b0; MEM_RDATA = 32'h0;
    total++; if (ReadData_OUT !== 32'h22222222) begin bad++; $display("FAIL b2b_second_data got=%h want=22222222", ReadData_OUT); end
    clear_inputs();
    tick();
  endtask

  task automatic test_timeout();
    MemRead_IN = 1'b1; ALUResult_IN = 32'h500;
    tick();
    for (int i = 0; i < 4; i++) begin
      total++; if (STALL_PIPE !== 1'b1 || MEM_REQ !== 1'b1) begin bad++; $display("FAIL timeout_busy%0d got=%b/%b want=1/1", i, STALL_PIPE, MEM_REQ); end
      tick();
    end
    total++; if (ReadData_OUT !== 32'h0 || TIMEOUT_ERR !== 1'b1) begin bad++; $display("FAIL timeout_done got=%h/%b want=0/1", ReadData_OUT, TIMEOUT_ERR); end
    total++; if (STALL_PIPE !== 1'b0 || MEM_REQ !== 1'b0) begin bad++; $display("FAIL timeout_release got=%b/%b want=0/0", STALL_PIPE, MEM_REQ); end
    clear_inputs();
    for (int i = 0; i < 10; i++) tick();
    total++; if (TIMEOUT_ERR !== 1'b1 || MEM_REQ !== 1'b0) begin bad++; $display("FAIL timeout_sticky got=%b/%b want=1/0", TIMEOUT_ERR, MEM_REQ); end
  endtask

  task automatic test_reset_mid_access();
    MemRead_IN = 1'b1; ALUResult_IN = 32'h600;
    tick();
    total++; if (MEM_REQ !== 1'b1) begin bad++; $display("FAIL rst_busy_req got=%b want=1", MEM_REQ); end
    #2;
    RESET = 1'b0;
    #1;
    total++; if (MEM_REQ !== 1'b0 || MEM_ADDR !== 32'h0 || TIMEOUT_ERR !== 1'b0) begin bad++; $display("FAIL rst_async got=%b/%h/%b want=0/0/0", MEM_REQ, MEM_ADDR, TIMEOUT_ERR); end
    total++; if (STALL_PIPE !== 1'b1) begin bad++; $display("FAIL rst_stall_op got=%b want=1", STALL_PIPE); end
    MemRead_IN = 1'b0;
    #1;
    total++; if (STALL_PIPE !== 1'b0 || FLUSH_MEMWB !== 1'b0) begin bad++; $display("FAIL rst_stall_noop got=%b/%b want=0/0", STALL_PIPE, FLUSH_MEMWB); end
    tick();
    RESET = 1'b1;
    MEM_ACK = 1'b1; MEM_RDATA = 32'h99999999;
    tick();
    MEM_ACK = 1'b0; MEM_RDATA = 32'h0;
    total++; if (ReadData_OUT !== 32'h0 || MEM_REQ !== 1'b0) begin bad++; $display("FAIL rst_stray_ack got=%h/%b want=0/0", ReadData_OUT, MEM_REQ); end
    // Only IDLE raises the stall on a fresh op, so this proves no DONE followed.
    MemRead_IN = 1'b1; ALUResult_IN = 32'h700;
    #1;
    total++; if (STALL_PIPE !== 1'b1) begin bad++; $display("FAIL rst_back_idle got=%b want=1", STALL_PIPE); end
    MEM_ACK = 1'b0;
    tick();
    MEM_ACK = 1'b1; MEM_RDATA = 32'h700D700D;
    tick();
    clear_inputs();
    total++; if (ReadData_OUT !== 32'h700D700D || MEM_ADDR !== 32'h700) begin bad++; $display("FAIL rst_recover got=%h/%h want=700d700d/700", ReadData_OUT, MEM_ADDR); end
    tick();
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_read_write_conflict();
    test_ack_at_limit();
    test_back_to_back();
    test_timeout();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of BUSY cycles to wait for MEM_ACK before aborting.
REQ-002 The block SHALL have port CLOCK  input  1  system clock; all state changes occur on the rising edge.
REQ-003 The block SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port MemRead_IN  input  1  EXE/MEM stage holds a load.
REQ-005 The block SHALL have port MemWrite_IN  input  1  EXE/MEM stage holds a store.
REQ-006 The block SHALL have port ALUResult_IN  input  32  memory byte address from EXE/MEM.
REQ-007 The block SHALL have port MemWriteData_IN  input  32  store data from EXE/MEM.
REQ-008 The block SHALL have port MemControl_IN  input  6  access size/sign code from EXE/MEM, passed to memory.
REQ-009 The block SHALL have port MEM_ACK  input  1  one-cycle pulse from data memory: access complete.
REQ-010 The block SHALL have port MEM_RDATA  input  32  read data, valid only while MEM_ACK=1.
REQ-011 The block SHALL have port MEM_REQ  output  1  registered request to data memory.
REQ-012 The block SHALL have port MEM_WE  output  1  registered write enable, valid with MEM_REQ.
REQ-013 The block SHALL have ports MEM_ADDR / MEM_WDATA / MEM_CTRL  output  32/32/6  registered request fields, valid with MEM_REQ.
REQ-014 The block SHALL have port STALL_PIPE  output  1  stall to IF/ID, ID/EXE and EXE/MEM registers.
REQ-015 The block SHALL have port FLUSH_MEMWB  output  1  bubble into MEM/WB register.
REQ-016 The block SHALL have port ReadData_OUT  output  32  captured load data for MEM/WB.
REQ-017 The block SHALL have port TIMEOUT_ERR  output  1  sticky flag: an access timed out.

Function
REQ-018 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-019 In IDLE with MemRead_IN|MemWrite_IN=1: STALL_PIPE=1 and FLUSH_MEMWB=1 combinationally; next state BUSY; MEM_REQ<=1, MEM_WE<=MemWrite_IN; MEM_ADDR, MEM_WDATA and MEM_CTRL latched from the inputs; cycle counter<=0.
REQ-020 If MemRead_IN and MemWrite_IN are both 1, the access SHALL be treated as a write (MEM_WE=1).
REQ-021 In IDLE with no memory op: STALL_PIPE=0, FLUSH_MEMWB=0, MEM_REQ=0; state remains IDLE.
REQ-022 In BUSY: STALL_PIPE=1 and FLUSH_MEMWB=1; MEM_REQ and all request fields SHALL hold stable; counter increments by 1 per cycle, saturating.
REQ-023 BUSY with MEM_ACK=1: MEM_REQ<=0; ReadData_OUT<=MEM_RDATA if MEM_WE=0, else ReadData_OUT unchanged; next state DONE.
REQ-024 BUSY with counter==TIMEOUT_CYCLES-1 and MEM_ACK=0: MEM_REQ<=0, ReadData_OUT<=0, TIMEOUT_ERR<=1; next state DONE.
REQ-025 MEM_ACK and timeout in the same cycle: MEM_ACK SHALL win; data captured, TIMEOUT_ERR unchanged.
REQ-026 In DONE: STALL_PIPE=0 and FLUSH_MEMWB=0 for exactly one cycle, so EXE/MEM advances and MEM/WB captures ReadData_OUT; next state IDLE unconditionally; memory-op inputs are ignored in DONE.
REQ-027 MEM_ACK received in IDLE or DONE SHALL be ignored with no state or output change.
REQ-028 Minimum access latency SHALL be 3 cycles: detect (IDLE), at least 1 BUSY, then DONE.
REQ-029 TIMEOUT_ERR SHALL clear only on reset.

Reset
REQ-030 While RESET=0, regardless of CLOCK: state=IDLE, MEM_REQ=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, MEM_CTRL=0, ReadData_OUT=0, counter=0, TIMEOUT_ERR=0.
REQ-031 Reset asserted mid-access (BUSY) SHALL drop MEM_REQ immediately and abandon the access; no DONE cycle follows.
REQ-032 While reset is asserted, STALL_PIPE and FLUSH_MEMWB SHALL be 0 unless a memory op is present on the inputs.

Verification
REQ-033 Load, addr 0x100, MEM_ACK 2 cycles after MEM_REQ, RDATA 0xDEADBEEF -> STALL_PIPE high 3 cycles, MEM_WE=0, ReadData_OUT=0xDEADBEEF in DONE, STALL_PIPE=0 in DONE.
REQ-034 Store, addr 0x200, data 0x12345678, ACK 1 cycle after MEM_REQ -> MEM_WE=1, MEM_WDATA=0x12345678 stable until ACK, ReadData_OUT unchanged.
REQ-035 Load with no ACK, TIMEOUT_CYCLES=4 -> 4 BUSY cycles, then DONE with ReadData_OUT=0, TIMEOUT_ERR=1 and still 1 after 10 idle cycles.
REQ-036 ACK on the same cycle as the timeout limit -> data captured, TIMEOUT_ERR=0.
REQ-037 Back-to-back loads -> IDLE re-detects the second load the cycle after DONE; the first load is not reissued.
REQ-038 RESET low during BUSY -> MEM_REQ=0 asynchronously, state IDLE; stray ACK after release ignored.
